// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH+1 edges from Start to Done.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q, neg_r;

    always_comb begin
        a_neg = Dividend[WIDTH-1];
        b_neg = Divisor[WIDTH-1];
        mag_a = a_neg ? -Dividend : Dividend;
        mag_b = b_neg ? -Divisor  : Divisor;
    end

    // The core works on magnitudes; signs are applied on the way out so Done latency is unchanged.
    always_comb begin
        Quotient  = neg_q ? -quo : quo;
        Remainder = neg_r ? -rem : rem;
    end
`else
    always_comb begin
        mag_a     = Dividend;
        mag_b     = Divisor;
        Quotient  = quo;
        Remainder = rem;
    end
`endif

    // Restoring step: the shifted partial remainder is WIDTH+1 bits wide, so compare before subtracting.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvsr});
        diff    = shifted[WIDTH-1:0] - dvsr;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_next = (Divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (count == CW'(WIDTH - 1)) state_next = DONE;
            end
            DONE: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            DivZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        count <= '0;
                        dvsr  <= mag_b;
                        if (Divisor == '0) begin
                            quo     <= '1;
                            rem     <= Dividend;
                            DivZero <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
`endif
                        end else begin
                            quo     <= mag_a;
                            rem     <= '0;
                            DivZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
`endif
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    rem   <= fits ? diff : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], fits};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             Start;
    logic [WIDTH-1:0] Dividend, Divisor;
    logic             Busy, Done, DivZero;
    logic [WIDTH-1:0] Quotient, Remainder;

    int tests = 0;
    int fails = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Busy     (Busy),
        .Done     (Done),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .DivZero  (DivZero)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands, with the divide-by-zero and overflow rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        dz = (b == 0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
`else
        dz = (b == 0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
    endtask

    // Called right after issue(): the next posedge accepts. Negedge n stands for edge n after acceptance.
    task automatic collect(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int poke_at, input bit hold);
        logic [31:0] eq, er;
        logic        edz;
        int          n;
        int          exp_lat;
        model(a, b, eq, er, edz);
        exp_lat = (b == 0) ? 1 : WIDTH + 1;
        @(negedge CLK);
        n = 1;
        if (!hold) begin
            Start    = 1'b0;
            Dividend = $urandom;
            Divisor  = $urandom;
        end
        check({tag, ".busy"}, 64'(Busy), 64'd1);
        while (Done !== 1'b1 && n < WIDTH + 10) begin
            if (!hold) begin
                if (n == poke_at - 1) begin
                    Start    = 1'b1;
                    Dividend = $urandom;
                    Divisor  = $urandom | 32'h1;
                end else begin
                    Start = 1'b0;
                end
            end
            @(negedge CLK);
            n++;
        end
        if (!hold) Start = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".quotient"}, 64'(Quotient), 64'(eq));
        check({tag, ".remainder"}, 64'(Remainder), 64'(er));
        check({tag, ".divzero"}, 64'(DivZero), 64'(edz));
        @(negedge CLK);
        check({tag, ".done_pulse"}, 64'({Done, Busy}), 64'd0);
        check({tag, ".held_q"}, 64'(Quotient), 64'(eq));
    endtask

    initial begin
        logic [31:0] a, b;
        bit          seen_done;
        int          n;

        RST_N    = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset.busy_done", 64'({Busy, Done}), 64'd0);
        check("reset.quotient", 64'(Quotient), 64'd0);
        check("reset.remainder", 64'(Remainder), 64'd0);
        check("reset.divzero", 64'(DivZero), 64'd0);
        RST_N = 1'b1;

        issue(32'd100, 32'd7);               collect("div_100_7", 32'd100, 32'd7, 0, 0);
        check("div_100_7.const_q", 64'(Quotient), 64'd14);
        check("div_100_7.const_r", 64'(Remainder), 64'd2);
        issue(32'hFFFF_FFFF, 32'd1);         collect("div_max_1", 32'hFFFF_FFFF, 32'd1, 0, 0);
        issue(32'd5, 32'd9);                 collect("div_5_9", 32'd5, 32'd9, 0, 0);
        issue(32'd1234, 32'd0);              collect("div_by_zero", 32'd1234, 32'd0, 0, 0);
        check("div_by_zero.const_q", 64'(Quotient), 64'hFFFF_FFFF);
        issue(32'd100, 32'd7);               collect("start_in_run", 32'd100, 32'd7, 10, 0);
        issue(-32'sd7, 32'd2);               collect("div_m7_2", -32'sd7, 32'd2, 0, 0);
        issue(32'h8000_0000, 32'hFFFF_FFFF); collect("div_minneg", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

        // Reset asserted so that it is sampled on RUN edge 20.
        issue(32'd100, 32'd7);
        @(negedge CLK);
        Start     = 1'b0;
        n         = 1;
        seen_done = 1'b0;
        while (n < 19) begin
            @(negedge CLK);
            n++;
            if (Done === 1'b1) seen_done = 1'b1;
        end
        RST_N = 1'b0;
        @(negedge CLK);
        check("abort.outputs", 64'({Busy, Done, DivZero}), 64'd0);
        check("abort.quotient", 64'(Quotient), 64'd0);
        check("abort.remainder", 64'(Remainder), 64'd0);
        repeat (3) begin
            @(negedge CLK);
            if (Done === 1'b1) seen_done = 1'b1;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        RST_N    = 1'b1;
        Start    = 1'b1;
        Dividend = 32'd40;
        Divisor  = 32'd8;
        collect("after_abort", 32'd40, 32'd8, 0, 0);
        check("after_abort.const_q", 64'(Quotient), 64'd5);

        // Start held high: one IDLE cycle, then the next acceptance.
        issue(32'd1000, 32'd3);
        collect("b2b_first", 32'd1000, 32'd3, 0, 1);
        collect("b2b_second", 32'd1000, 32'd3, 0, 0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 8);
            endcase
            issue(a, b);
            collect($sformatf("rand%0d", i), a, b, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
